// File: rtl/l1_cache_ctrl.sv
// Two-way set-associative L1 cache controller with integrated tag/valid/LRU/data
// arrays. Write-through, no-write-allocate; read misses fill a full 64-byte line.
module l1_cache_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  phy_addr,
  input  logic [31:0]  data_from_cpu,
  input  logic         read_mem,
  input  logic         write_mem,
  output logic [31:0]  data_to_cpu,
  output logic         hit_miss,
  output logic         ready_stall,
  output logic [31:0]  main_mem_addr,
  output logic [31:0]  main_mem_data_out,
  output logic         main_mem_read_req,
  output logic         main_mem_write_req,
  input  logic [511:0] main_mem_data_in,
  input  logic         main_mem_ready
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RD_WAIT, WR_WAIT} state_t;

  state_t state, state_nxt;

  // Latched request
  logic        req_prev;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        op_wr_q;

  // Storage: data/tag indexed [way][set]; valid per set is {way1, way0};
  // lru[set] names the way to evict next.
  logic [511:0] data_arr  [2][64];
  logic [19:0]  tag_arr   [2][64];
  logic [1:0]   valid_arr [64];
  logic [63:0]  lru;

  logic [19:0] tag;
  logic [5:0]  set;
  logic [3:0]  word;
  logic        hit0, hit1, hit, hit_way, victim, accept;
  logic [511:0] hit_line;

  assign tag  = addr_q[31:12];
  assign set  = addr_q[11:6];
  assign word = addr_q[5:2];

  assign hit0     = valid_arr[set][0] && (tag_arr[0][set] == tag);
  assign hit1     = valid_arr[set][1] && (tag_arr[1][set] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = !hit0;
  assign hit_line = hit0 ? data_arr[0][set] : data_arr[1][set];

  // Fill victim: invalid way0, then invalid way1, else the LRU way.
  assign victim = !valid_arr[set][0] ? 1'b0 :
                  !valid_arr[set][1] ? 1'b1 : lru[set];

  // Only a rising edge of the combined strobe starts a request.
  assign accept = (state == IDLE) && (read_mem | write_mem) && !req_prev;

  assign ready_stall = (state != IDLE);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = op_wr_q ? WR_WAIT : (hit ? IDLE : RD_WAIT);
      RD_WAIT: if (main_mem_ready) state_nxt = IDLE;
      WR_WAIT: if (main_mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Control registers, outputs, valid and LRU bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_prev           <= 1'b0;
      addr_q             <= '0;
      wdata_q            <= '0;
      op_wr_q            <= 1'b0;
      data_to_cpu        <= '0;
      hit_miss           <= 1'b0;
      main_mem_addr      <= '0;
      main_mem_data_out  <= '0;
      main_mem_read_req  <= 1'b0;
      main_mem_write_req <= 1'b0;
      lru                <= '0;
      for (int s = 0; s < 64; s++) valid_arr[s] <= 2'b00;
    end else begin
      req_prev           <= read_mem | write_mem;
      main_mem_read_req  <= 1'b0;
      main_mem_write_req <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          addr_q  <= phy_addr;
          wdata_q <= data_from_cpu;
          op_wr_q <= write_mem;
        end
        LOOKUP: begin
          hit_miss <= hit;
          if (op_wr_q) begin
            main_mem_addr      <= addr_q;
            main_mem_data_out  <= wdata_q;
            main_mem_write_req <= 1'b1;
            if (hit) lru[set] <= ~hit_way;
          end else if (hit) begin
            data_to_cpu <= hit_line[{word, 5'b0} +: 32];
            lru[set]    <= ~hit_way;
          end else begin
            main_mem_addr     <= {addr_q[31:6], 6'b0};
            main_mem_read_req <= 1'b1;
          end
        end
        RD_WAIT: if (main_mem_ready) begin
          valid_arr[set][victim] <= 1'b1;
          lru[set]               <= ~victim;
          data_to_cpu            <= main_mem_data_in[{word, 5'b0} +: 32];
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: line fill on read miss, word update on write hit
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == RD_WAIT && main_mem_ready) begin
        data_arr[victim][set] <= main_mem_data_in;
        tag_arr[victim][set]  <= tag;
      end else if (state == LOOKUP && op_wr_q && hit) begin
        data_arr[hit_way][set][{word, 5'b0} +: 32] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Self-checking bench for l1_cache_ctrl: directed vector table, hand-written
// corner sequences, then random traffic against a recency-list cache model.
module tb_l1_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  phy_addr, data_from_cpu;
  logic         read_mem, write_mem;
  logic [31:0]  data_to_cpu;
  logic         hit_miss, ready_stall;
  logic [31:0]  main_mem_addr, main_mem_data_out;
  logic         main_mem_read_req, main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;

  always #5 clk = ~clk;

  l1_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .phy_addr(phy_addr), .data_from_cpu(data_from_cpu),
    .read_mem(read_mem), .write_mem(write_mem), .data_to_cpu(data_to_cpu),
    .hit_miss(hit_miss), .ready_stall(ready_stall), .main_mem_addr(main_mem_addr),
    .main_mem_data_out(main_mem_data_out), .main_mem_read_req(main_mem_read_req),
    .main_mem_write_req(main_mem_write_req), .main_mem_data_in(main_mem_data_in),
    .main_mem_ready(main_mem_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory: word k holds k unless written.
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] mword(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    return mem.exists(k) ? mem[k] : a >> 2;
  endfunction

  // Cache model: per set, a list of resident tags, most recent first, max 2.
  // Cache contents always equal memory (write-through, fills from memory).
  logic [19:0] rec [64][$];

  function automatic bit m_hit(input logic [31:0] a);
    foreach (rec[a[11:6]][i]) if (rec[a[11:6]][i] == a[31:12]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_touch(input logic [31:0] a, input bit fill);
    int s;
    int idx;
    s = a[11:6];
    idx = -1;
    foreach (rec[s][i]) if (rec[s][i] == a[31:12]) idx = i;
    if (idx >= 0) begin
      rec[s].delete(idx);
      rec[s].push_front(a[31:12]);
    end else if (fill) begin
      rec[s].push_front(a[31:12]);
      if (rec[s].size() > 2) void'(rec[s].pop_back());
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < 64; s++) rec[s].delete();
  endtask

  // Drive one request, play the memory side with the given latency, check.
  task automatic do_op(input string nm, input bit wr, input bit both,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input bit exp_hit, input logic [31:0] exp_data);
    logic [31:0] ra, wa, wd, la;
    int nrd, nwr, stall, cnt;
    bit done;
    nrd = 0; nwr = 0; stall = 0; cnt = -1; done = 0;
    ra = '0; wa = '0; wd = '0;
    @(negedge clk);
    phy_addr = a; data_from_cpu = d;
    write_mem = wr; read_mem = !wr || both;
    @(negedge clk);
    read_mem = 0; write_mem = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (c > 0) @(negedge clk);
      main_mem_ready = 0;
      if (!ready_stall) done = 1;
      else begin
        stall++;
        if (main_mem_read_req)  begin nrd++; cnt = lat; end
        if (main_mem_write_req) begin nwr++; cnt = lat; end
        if (cnt == 0) begin
          ra = main_mem_addr; wa = main_mem_addr; wd = main_mem_data_out;
          for (int i = 0; i < 16; i++) begin
            la = {main_mem_addr[31:6], 6'b0} + 32'(4 * i);
            main_mem_data_in[32*i +: 32] = mword(la);
          end
          main_mem_ready = 1;
          cnt = -1;
        end else if (cnt > 0) cnt--;
      end
    end
    chk({nm, " done"}, done, 1);
    chk({nm, " hit_miss"}, hit_miss, exp_hit);
    chk({nm, " stall_cycles"}, stall, (!wr && exp_hit) ? 1 : 2 + lat);
    chk({nm, " rd_reqs"}, nrd, (!wr && !exp_hit) ? 1 : 0);
    chk({nm, " wr_reqs"}, nwr, wr ? 1 : 0);
    if (wr) begin
      chk({nm, " wr_addr"}, wa, a);
      chk({nm, " wr_data"}, wd, d);
    end else begin
      if (!exp_hit) chk({nm, " rd_addr"}, ra, {a[31:6], 6'b0});
      chk({nm, " data_to_cpu"}, data_to_cpu, exp_data);
    end
  endtask

  // Run one op and keep the model in step.
  task automatic run_op(input string nm, input bit wr, input bit both,
                        input logic [31:0] a, input logic [31:0] d, input int lat,
                        input bit use_model, input bit t_hit, input logic [31:0] t_data);
    bit eh;
    logic [31:0] ed;
    eh = use_model ? m_hit(a) : t_hit;
    ed = use_model ? mword(a) : t_data;
    do_op(nm, wr, both, a, d, lat, eh, ed);
    if (wr) begin
      mem[a >> 2] = d;
      if (m_hit(a)) m_touch(a, 1'b0);
    end else m_touch(a, 1'b1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          hit;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int nrd, nst;
    logic [31:0] ra;
    bit seen;
    tbl[0] = '{0, 32'h0000_0040, 32'h0, 0, 32'h0000_0010};
    tbl[1] = '{0, 32'h0000_0044, 32'h0, 1, 32'h0000_0011};
    tbl[2] = '{1, 32'h0000_0044, 32'hDEAD_BEEF, 1, 32'h0};
    tbl[3] = '{0, 32'h0000_0044, 32'h0, 1, 32'hDEAD_BEEF};
    tbl[4] = '{0, 32'h0000_1040, 32'h0, 0, 32'h0000_0410};
    tbl[5] = '{0, 32'h0000_2040, 32'h0, 0, 32'h0000_0810};
    tbl[6] = '{0, 32'h0000_1040, 32'h0, 1, 32'h0000_0410};
    tbl[7] = '{0, 32'h0000_0044, 32'h0, 0, 32'hDEAD_BEEF};
    tbl[8] = '{1, 32'h0000_3000, 32'h1234_5678, 0, 32'h0};
    tbl[9] = '{0, 32'h0000_3000, 32'h0, 0, 32'h1234_5678};

    rst_n = 0; read_mem = 0; write_mem = 0; phy_addr = '0; data_from_cpu = '0;
    main_mem_ready = 0; main_mem_data_in = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst data_to_cpu", data_to_cpu, 0);
    chk("rst hit_miss", hit_miss, 0);
    chk("rst ready_stall", ready_stall, 0);
    chk("rst rd_req", main_mem_read_req, 0);
    chk("rst wr_req", main_mem_write_req, 0);
    chk("rst mem_addr", main_mem_addr, 0);
    chk("rst mem_data", main_mem_data_out, 0);

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].wr, 1'b0, tbl[i].a, tbl[i].d, i % 3,
             1'b0, tbl[i].hit, tbl[i].data);

    // Stray ready while idle is ignored.
    @(negedge clk); main_mem_ready = 1;
    @(negedge clk); main_mem_ready = 0;
    chk("idle ready ignored", ready_stall, 0);

    // Strobe held 5 cycles: one lookup (hit on 0x3000), no memory traffic.
    nrd = 0; nst = 0;
    @(negedge clk); phy_addr = 32'h0000_3000; read_mem = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 4) read_mem = 0;
      if (ready_stall) nst++;
      if (main_mem_read_req || main_mem_write_req) nrd++;
    end
    chk("held strobe stall_cycles", nst, 1);
    chk("held strobe mem_reqs", nrd, 0);
    chk("held strobe hit_miss", hit_miss, 1);
    chk("held strobe data", data_to_cpu, 32'h1234_5678);
    m_touch(32'h0000_3000, 1'b1);

    // Both strobes: a write, hitting the cached 0x3000 line.
    run_op("both strobes", 1'b1, 1'b1, 32'h0000_3004, 32'hCAFE_F00D, 1, 1'b1, 1'b0, '0);

    // Reset during RD_WAIT abandons the fill and clears the cache.
    @(negedge clk); phy_addr = 32'h0000_5000; read_mem = 1;
    @(negedge clk); read_mem = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (main_mem_read_req) seen = 1;
    end
    chk("rd_wait reached", seen, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst ready_stall", ready_stall, 0);
    chk("midrst rd_req", main_mem_read_req, 0);
    chk("midrst wr_req", main_mem_write_req, 0);
    chk("midrst hit_miss", hit_miss, 0);
    m_reset();
    run_op("reread after reset", 1'b0, 1'b0, 32'h0000_5000, '0, 2, 1'b0, 1'b0, 32'h0000_1400);
    run_op("reread 0x3000", 1'b0, 1'b0, 32'h0000_3000, '0, 1, 1'b0, 1'b0, 32'h1234_5678);

    // Random traffic over a few sets and tags to provoke hits and evictions.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      bit wr;
      a = {12'h0, 8'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      wr = ($urandom_range(0, 3) == 0);
      run_op($sformatf("rnd%0d", n), wr, wr && $urandom_range(0, 1) == 1, a,
             $urandom, $urandom_range(0, 3), 1'b1, 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
